tcam_mmio_master: RTL and testbench
===================================

# tcam_mmio_master

Bus-initiator sequencer that drives the TCAM MMIO register window at `BASE_ADDR`. It sits between a packet-parser or loader client and the native memory bus. It turns single-cycle table-write and lookup commands into the required ordered MMIO write/read sequence. For lookups it returns hit/index results on a valid/ready response channel.

## Interface
- `ENTRIES`, 16, TCAM depth; `IDX_W = $clog2(ENTRIES)`.
- `BASE_ADDR`, 32'h0300_0000, base of TCAM register window.
- `LOOKUP_WAIT`, 4, idle bus cycles between the key_valid write and the hit read (≥1).
- `TIMEOUT`, 255, max cycles `mem_valid` waits for `mem_ready` before abort (8-bit counter).
- `clk  in  1  clock`
- `resetn  in  1  reset, asynchronous, active-low`
- `cmd_valid  in  1  command offered`
- `cmd_ready  out  1  command accepted when high with cmd_valid`
- `cmd_op  in  1  0 = write entry, 1 = lookup`
- `cmd_index  in  IDX_W  entry index (write only)`
- `cmd_is_mask  in  1  1 = write mask plane, 0 = value plane (write only)`
- `cmd_data  in  128  entry data (write) or search key (lookup)`
- `rsp_valid  out  1  response available`
- `rsp_ready  in  1  response consumed`
- `rsp_op  out  1  echo of cmd_op`
- `rsp_hit  out  1  lookup hit (0 for writes)`
- `rsp_index  out  IDX_W  lookup hit index (0 for writes)`
- `rsp_err  out  1  bus timeout occurred`
- `busy  out  1  high in every state except IDLE`
- `mem_valid  out  1  bus request`
- `mem_ready  in  1  bus completion`
- `mem_addr  out  32  bus address`
- `mem_wdata  out  32  write data`
- `mem_wstrb  out  4  4'hF for writes, 4'h0 for reads`
- `mem_rdata  in  32  read data, valid in the completion cycle`

## Operation
- States: IDLE, WR_SEQ, LK_SEQ, LK_WAIT, LK_RD_HIT, LK_RD_IDX, RSP.
- IDLE: `cmd_ready = 1`. On `cmd_valid && cmd_ready`, latch all cmd fields, clear step counter, clear `rsp_err`. Go to WR_SEQ (op 0) or LK_SEQ (op 1).
- WR_SEQ issues 7 writes in order:
  - `+0x20` = `{0, index}`
  - `+0x24` = `{31'b0, is_mask}`
  - `+0x28` = `data[31:0]`, `+0x2C` = `data[63:32]`, `+0x30` = `data[95:64]`, `+0x34` = `data[127:96]`
  - `+0x38` = 1
  - Then go to RSP with `hit = 0`, `index = 0`.
- LK_SEQ issues 5 writes: `+0x00`..`+0x0C` = key words, low word first; then `+0x10` = 1. Then go to LK_WAIT.
- LK_WAIT: `mem_valid = 0` for exactly `LOOKUP_WAIT` cycles, then go to LK_RD_HIT.
- LK_RD_HIT: read `+0x14`, capture `rdata[0]` into `hit`. Then go to LK_RD_IDX.
- LK_RD_IDX: read `+0x18`, capture `rdata[IDX_W-1:0]` into `index`. Then go to RSP.
- RSP: `rsp_valid = 1` with all rsp fields stable. On `rsp_ready`, go to IDLE.
- Timeout: the counter resets on each completion. If `mem_valid` is high for `TIMEOUT` cycles without `mem_ready`:
  - deassert `mem_valid`;
  - set `rsp_err = 1`, `hit = 0`, `index = 0`;
  - skip the remaining steps and go to RSP.
- Commands are never queued; `cmd_ready` is 0 outside IDLE.

## Timing
- Bus rule: a transaction completes at the posedge where `mem_valid && mem_ready`.
- Once `mem_valid` rises, `mem_addr`/`mem_wdata`/`mem_wstrb` stay stable until completion.
- Back-to-back: after a completion within a sequence, the next step's `mem_valid`/addr/data are driven in the following cycle without a gap. One transaction per cycle is possible with a zero-wait responder.
- `mem_valid` falls the cycle after the last completion of WR_SEQ, LK_SEQ and LK_RD_IDX.
- Read data is sampled only at the completion posedge. `mem_rdata` in other cycles is ignored.
- Latency with a zero-wait responder:
  - write command: accept → `rsp_valid` = 8 cycles (7 bus + 1);
  - lookup command: accept → `rsp_valid` = 5 + `LOOKUP_WAIT` + 2 + 1 cycles.
- `rsp_valid` holds indefinitely until `rsp_ready`. The response clears the cycle after the handshake.
- Reset values: `mem_valid = 0`, `mem_addr = 0`, `mem_wdata = 0`, `mem_wstrb = 0`, `rsp_valid = 0`, `rsp_op = 0`, `rsp_hit = 0`, `rsp_index = 0`, `rsp_err = 0`, `busy = 0`, `cmd_ready = 1` once resetn is high.
- Reset mid-sequence aborts immediately. `mem_valid` drops asynchronously and the state returns to IDLE. No partial sequence is resumed.
- `LOOKUP_WAIT` counter width is `$clog2(LOOKUP_WAIT+1)`. Address arithmetic is `BASE_ADDR + offset`, 32-bit, no wrap check.

## Test plan
- Write entry: `cmd_op = 0`, `index = 5`, `is_mask = 1`, `data = 128'h0123..CDEF` against a zero-wait tcam_mmio model → exactly 7 writes in order 0x0300_0020..0x0300_0038 with wdata 5, 1, data words low first, 1. `rsp_valid` 8 cycles after accept, `rsp_err = 0`.
- Lookup hit: program entry 3 with mask 0 and value K, then look up K with `LOOKUP_WAIT = 4` → 5 writes, 4 idle cycles, reads at 0x14 and 0x18; response `rsp_hit = 1`, `rsp_index = 3`.
- Lookup miss: key not matching any entry → `rsp_hit = 0`, `rsp_index = 0`, `rsp_op = 1`.
- Wait states: responder inserts 3 cycles of `mem_ready = 0` before each completion → addr/wdata/wstrb stable throughout, same transaction order and results, latency grows by 3 per transaction.
- Timeout and backpressure: responder never asserts ready → `mem_valid` drops after 255 cycles, `rsp_err = 1`. With `rsp_ready` held low for 10 cycles, `rsp_valid` and fields stay stable and `cmd_ready` stays 0.
- Reset: assert resetn low during step 3 of WR_SEQ → `mem_valid = 0` immediately; after release `cmd_ready = 1`, `rsp_valid = 0`, and a new lookup completes correctly.

Source files
------------

// File: rtl/tcam_mmio_master.sv
// Bus-initiator sequencer for the TCAM MMIO window: expands single-cycle write/lookup
// commands into ordered MMIO transactions and returns lookup results on a response channel.
module tcam_mmio_master #(
  parameter int          ENTRIES     = 16,
  parameter int          IDX_W       = $clog2(ENTRIES),
  parameter logic [31:0] BASE_ADDR   = 32'h0300_0000,
  parameter int          LOOKUP_WAIT = 4,
  parameter int          TIMEOUT     = 255
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [IDX_W-1:0] cmd_index,
  input  logic             cmd_is_mask,
  input  logic [127:0]     cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_op,
  output logic             rsp_hit,
  output logic [IDX_W-1:0] rsp_index,
  output logic             rsp_err,
  output logic             busy,
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata
);

  // state       | meaning
  // S_IDLE      | waiting for a command, cmd_ready high
  // S_WR_SEQ    | 7 writes: index, plane, 4 data words, commit
  // S_LK_SEQ    | 5 writes: 4 key words, key_valid
  // S_LK_WAIT   | LOOKUP_WAIT idle bus cycles while the TCAM searches
  // S_LK_RD_HIT | read hit flag
  // S_LK_RD_IDX | read hit index
  // S_RSP       | response held until rsp_ready
  typedef enum logic [2:0] {
    S_IDLE, S_WR_SEQ, S_LK_SEQ, S_LK_WAIT, S_LK_RD_HIT, S_LK_RD_IDX, S_RSP
  } state_t;

  localparam int         WAIT_W    = $clog2(LOOKUP_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(LOOKUP_WAIT);
  localparam logic [7:0] TO_LOAD   = 8'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [2:0]        step;
  logic [WAIT_W-1:0] wait_cnt;
  logic [7:0]        to_cnt;
  logic              is_mask_q;
  logic [IDX_W-1:0]  index_q;
  logic [127:0]      data_q;
  logic              mem_done;
  logic              mem_tout;
  logic              unused_rdata;

  assign mem_done     = mem_valid && mem_ready;
  assign mem_tout     = mem_valid && !mem_ready && (to_cnt == 8'd0);
  assign unused_rdata = ^mem_rdata[31:IDX_W];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (cmd_valid) state_nxt = cmd_op ? S_LK_SEQ : S_WR_SEQ;
      S_WR_SEQ:    if (mem_tout || (mem_done && step == 3'd6)) state_nxt = S_RSP;
      S_LK_SEQ: begin
        if (mem_tout)                         state_nxt = S_RSP;
        else if (mem_done && step == 3'd4)    state_nxt = S_LK_WAIT;
      end
      S_LK_WAIT:   if (wait_cnt == WAIT_W'(1)) state_nxt = S_LK_RD_HIT;
      S_LK_RD_HIT: begin
        if (mem_tout)      state_nxt = S_RSP;
        else if (mem_done) state_nxt = S_LK_RD_IDX;
      end
      S_LK_RD_IDX: if (mem_tout || mem_done) state_nxt = S_RSP;
      S_RSP:       if (rsp_ready) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from state/step so a stalled transaction holds addr/data unchanged.
  always_comb begin
    mem_valid = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    case (state)
      S_WR_SEQ: begin
        mem_valid = 1'b1;
        mem_wstrb = 4'hF;
        mem_addr  = BASE_ADDR + 32'h20 + {27'b0, step, 2'b00};
        case (step)
          3'd0:    mem_wdata = {{(32-IDX_W){1'b0}}, index_q};
          3'd1:    mem_wdata = {31'b0, is_mask_q};
          3'd2:    mem_wdata = data_q[31:0];
          3'd3:    mem_wdata = data_q[63:32];
          3'd4:    mem_wdata = data_q[95:64];
          3'd5:    mem_wdata = data_q[127:96];
          3'd6:    mem_wdata = 32'h1;
          default: mem_wdata = 32'h0;
        endcase
      end
      S_LK_SEQ: begin
        mem_valid = 1'b1;
        mem_wstrb = 4'hF;
        mem_addr  = BASE_ADDR + {27'b0, step, 2'b00};
        case (step)
          3'd0:    mem_wdata = data_q[31:0];
          3'd1:    mem_wdata = data_q[63:32];
          3'd2:    mem_wdata = data_q[95:64];
          3'd3:    mem_wdata = data_q[127:96];
          3'd4:    mem_wdata = 32'h1;
          default: mem_wdata = 32'h0;
        endcase
      end
      S_LK_RD_HIT: begin
        mem_valid = 1'b1;
        mem_addr  = BASE_ADDR + 32'h14;
      end
      S_LK_RD_IDX: begin
        mem_valid = 1'b1;
        mem_addr  = BASE_ADDR + 32'h18;
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RSP);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      step      <= 3'd0;
      wait_cnt  <= '0;
      to_cnt    <= TO_LOAD;
      is_mask_q <= 1'b0;
      index_q   <= '0;
      data_q    <= '0;
      rsp_op    <= 1'b0;
      rsp_hit   <= 1'b0;
      rsp_index <= '0;
      rsp_err   <= 1'b0;
    end else if (state == S_IDLE) begin
      if (cmd_valid) begin
        step      <= 3'd0;
        to_cnt    <= TO_LOAD;
        is_mask_q <= cmd_is_mask;
        index_q   <= cmd_index;
        data_q    <= cmd_data;
        rsp_op    <= cmd_op;
        rsp_hit   <= 1'b0;
        rsp_index <= '0;
        rsp_err   <= 1'b0;
      end
    end else begin
      // Timeout down-counter restarts on every completion; idle cycles do not consume it.
      if (mem_done) begin
        step   <= step + 3'd1;
        to_cnt <= TO_LOAD;
      end else if (mem_valid && to_cnt != 8'd0) begin
        to_cnt <= to_cnt - 8'd1;
      end
      if (mem_tout) begin
        rsp_err   <= 1'b1;
        rsp_hit   <= 1'b0;
        rsp_index <= '0;
      end
      if (state == S_LK_SEQ && mem_done && step == 3'd4) wait_cnt <= WAIT_LOAD;
      else if (state == S_LK_WAIT)                       wait_cnt <= wait_cnt - WAIT_W'(1);
      if (state == S_LK_RD_HIT && mem_done) rsp_hit   <= mem_rdata[0];
      if (state == S_LK_RD_IDX && mem_done) rsp_index <= mem_rdata[IDX_W-1:0];
    end
  end

endmodule

// File: tb/tb_tcam_mmio_master.sv
// Directed + randomized bench for tcam_mmio_master with a behavioural TCAM responder
// and transaction-level expectations.
module tb_tcam_mmio_master;
  localparam int          IDX_W = 4;
  localparam logic [31:0] BASE  = 32'h0300_0000;
  localparam int          LW    = 4;

  logic             clk, resetn;
  logic             cmd_valid, cmd_ready, cmd_op, cmd_is_mask;
  logic [IDX_W-1:0] cmd_index;
  logic [127:0]     cmd_data;
  logic             rsp_valid, rsp_ready, rsp_op, rsp_hit, rsp_err, busy;
  logic [IDX_W-1:0] rsp_index;
  logic             mem_valid, mem_ready;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;
  logic [3:0]       mem_wstrb;

  tcam_mmio_master dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_index(cmd_index), .cmd_is_mask(cmd_is_mask), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_hit(rsp_hit), .rsp_index(rsp_index), .rsp_err(rsp_err), .busy(busy),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          stamp;
  } txn_t;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Behavioural TCAM: mask bit 1 = don't care, lowest valid matching entry wins.
  logic [127:0] tab_val [16];
  logic [127:0] tab_msk [16];
  bit           tab_vld [16];
  logic [31:0]  stg_idx, stg_msk;
  logic [31:0]  stg_d [4];
  logic [31:0]  key_w [4];
  logic         lk_hit;
  logic [3:0]   lk_idx;

  function automatic logic [4:0] ref_lookup(input logic [127:0] key);
    for (int e = 0; e < 16; e++)
      if (tab_vld[e] && (((key ^ tab_val[e]) & ~tab_msk[e]) == 128'h0))
        return {1'b1, 4'(e)};
    return 5'h0;
  endfunction

  int   ws_mode = 0;   // wait cycles before each completion; -1 never completes
  int   wcnt = 0;
  int   stamp = 0;
  txn_t obs_q[$];
  logic prev_valid = 1'b0, prev_ready = 1'b0;
  logic [67:0] prev_bus;

  always @(negedge clk) begin
    logic [31:0] r;
    logic [4:0]  lr;
    stamp++;
    mem_rdata = $urandom;
    if (prev_valid && !prev_ready && mem_valid)
      chk("bus_stable", {60'h0, mem_addr, mem_wdata, mem_wstrb}, {60'h0, prev_bus});
    if (!resetn || !mem_valid) begin
      mem_ready = 1'b0;
      wcnt = 0;
    end else if (ws_mode < 0 || wcnt < ws_mode) begin
      mem_ready = 1'b0;
      wcnt++;
    end else begin
      mem_ready = 1'b1;
      wcnt = 0;
      obs_q.push_back('{mem_addr, mem_wdata, mem_wstrb, stamp});
      if (mem_wstrb == 4'hF) begin
        case (mem_addr - BASE)
          32'h20: stg_idx = mem_wdata;
          32'h24: stg_msk = mem_wdata;
          32'h28: stg_d[0] = mem_wdata;
          32'h2C: stg_d[1] = mem_wdata;
          32'h30: stg_d[2] = mem_wdata;
          32'h34: stg_d[3] = mem_wdata;
          32'h38: begin
            if (stg_msk[0]) tab_msk[stg_idx[3:0]] = {stg_d[3], stg_d[2], stg_d[1], stg_d[0]};
            else            tab_val[stg_idx[3:0]] = {stg_d[3], stg_d[2], stg_d[1], stg_d[0]};
            tab_vld[stg_idx[3:0]] = 1'b1;
          end
          32'h00: key_w[0] = mem_wdata;
          32'h04: key_w[1] = mem_wdata;
          32'h08: key_w[2] = mem_wdata;
          32'h0C: key_w[3] = mem_wdata;
          32'h10: begin
            lr = ref_lookup({key_w[3], key_w[2], key_w[1], key_w[0]});
            lk_hit = lr[4];
            lk_idx = lr[3:0];
          end
          default: ;
        endcase
      end else begin
        r = $urandom;
        if (mem_addr == BASE + 32'h14) r[0] = lk_hit;
        if (mem_addr == BASE + 32'h18) r[3:0] = lk_idx;
        mem_rdata = r;
      end
    end
    prev_valid = mem_valid;
    prev_ready = mem_ready;
    prev_bus   = {mem_addr, mem_wdata, mem_wstrb};
  end

  task automatic run_cmd(input string tag, input logic op, input logic [3:0] idx,
                         input logic msk, input logic [127:0] data);
    txn_t exp_q[$];
    int n, lat, t_trig, t_rd;
    logic [4:0] er;
    if (!op) begin
      exp_q.push_back('{BASE + 32'h20, {28'h0, idx}, 4'hF, 0});
      exp_q.push_back('{BASE + 32'h24, {31'h0, msk}, 4'hF, 0});
      for (int w = 0; w < 4; w++)
        exp_q.push_back('{BASE + 32'h28 + 32'(4 * w), data[32*w +: 32], 4'hF, 0});
      exp_q.push_back('{BASE + 32'h38, 32'h1, 4'hF, 0});
      er  = 5'h0;
      lat = 8 + 7 * ws_mode;
    end else begin
      for (int w = 0; w < 4; w++)
        exp_q.push_back('{BASE + 32'(4 * w), data[32*w +: 32], 4'hF, 0});
      exp_q.push_back('{BASE + 32'h10, 32'h1, 4'hF, 0});
      exp_q.push_back('{BASE + 32'h14, 32'h0, 4'h0, 0});
      exp_q.push_back('{BASE + 32'h18, 32'h0, 4'h0, 0});
      er  = ref_lookup(data);
      lat = 5 + LW + 2 + 1 + 7 * ws_mode;
    end
    obs_q.delete();
    @(negedge clk);
    cmd_op = op; cmd_index = idx; cmd_is_mask = msk; cmd_data = data; cmd_valid = 1'b1;
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_ntxn"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_txn%0d", tag, i),
          {obs_q[i].addr, obs_q[i].wdata, obs_q[i].wstrb},
          {exp_q[i].addr, exp_q[i].wdata, exp_q[i].wstrb});
    if (op && obs_q.size() == 7) begin
      t_trig = obs_q[4].stamp;
      t_rd   = obs_q[5].stamp;
      chk({tag, "_wait_gap"}, t_rd - t_trig, LW + 1 + ws_mode);
    end
    chk({tag, "_rsp_op"}, rsp_op, op);
    chk({tag, "_rsp_hit"}, rsp_hit, er[4]);
    chk({tag, "_rsp_index"}, rsp_index, er[3:0]);
    chk({tag, "_rsp_err"}, rsp_err, 1'b0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk({tag, "_rsp_clear"}, {rsp_valid, busy, cmd_ready}, 3'b001);
  endtask

  initial begin
    logic [127:0] k, d;
    int mv, n;
    for (int e = 0; e < 16; e++) begin
      tab_val[e] = '0; tab_msk[e] = '0; tab_vld[e] = 1'b0;
    end
    resetn = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_index = '0;
    cmd_is_mask = 1'b0; cmd_data = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("reset_bus", {mem_valid, mem_addr, mem_wdata, mem_wstrb}, 69'h0);
    chk("reset_rsp", {rsp_valid, rsp_op, rsp_hit, rsp_index, rsp_err, busy}, 9'h0);
    chk("reset_cmd_ready", cmd_ready, 1'b1);

    run_cmd("wr_entry", 1'b0, 4'd5, 1'b1, 128'h01234567_89ABCDEF_01234567_89ABCDEF);

    k = {$urandom, $urandom, $urandom, $urandom};
    run_cmd("wr_k_val", 1'b0, 4'd3, 1'b0, k);
    run_cmd("wr_k_msk", 1'b0, 4'd3, 1'b1, 128'h0);
    run_cmd("lk_hit", 1'b1, 4'd0, 1'b0, k);
    chk("lk_hit_is_3", {rsp_hit, rsp_index}, 5'h13);
    run_cmd("lk_miss", 1'b1, 4'd0, 1'b0, ~k);

    for (int i = 0; i < 6; i++) begin
      ws_mode = $urandom_range(0, 2);
      d = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 0)
        run_cmd($sformatf("rnd%0d_wr", i), 1'b0, 4'($urandom_range(6, 15)), 1'($urandom_range(0, 1)), d);
      else
        run_cmd($sformatf("rnd%0d_lk", i), 1'b1, 4'd0, 1'b0, ($urandom_range(0, 1) == 0) ? k : d);
    end

    ws_mode = 3;
    run_cmd("ws_wr", 1'b0, 4'd9, 1'b0, {$urandom, $urandom, $urandom, $urandom});
    run_cmd("ws_lk", 1'b1, 4'd0, 1'b0, k);

    // Responder never completes: abort after TIMEOUT cycles, then hold the response.
    ws_mode = -1;
    obs_q.delete();
    @(negedge clk);
    cmd_op = 1'b0; cmd_index = 4'd2; cmd_data = '1; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    mv = 0; n = 0;
    while (n < 1000) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
      if (mem_valid) mv++;
    end
    chk("to_rsp_valid", rsp_valid, 1'b1);
    chk("to_valid_cycles", mv, 255);
    chk("to_ntxn", obs_q.size(), 0);
    chk("to_rsp", {rsp_op, rsp_hit, rsp_index, rsp_err}, 7'h01);
    cmd_op = 1'b1; cmd_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_hold", c), {rsp_valid, rsp_op, rsp_hit, rsp_index, rsp_err, busy, mem_valid},
          10'b1_0_0_0000_1_1_0);
      chk($sformatf("bp%0d_cmd_ready", c), cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("bp_release", {rsp_valid, cmd_ready}, 2'b01);

    // Reset in the middle of the fourth write of an entry update.
    ws_mode = 3;
    @(negedge clk);
    cmd_op = 1'b0; cmd_index = 4'd3; cmd_is_mask = 1'b0; cmd_data = ~k; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (mem_valid && mem_addr == BASE + 32'h2C) break;
    end
    chk("rst_reached_step3", {mem_valid, mem_addr}, {1'b1, BASE + 32'h2C});
    @(posedge clk);
    #1 resetn = 1'b0;
    #1 chk("rst_async_drop", {mem_valid, busy, mem_addr}, 34'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_after", {cmd_ready, rsp_valid, rsp_err}, 3'b100);
    ws_mode = 0;
    run_cmd("rst_lk", 1'b1, 4'd0, 1'b0, k);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
